// File: rtl/hex_segment_driver.sv
//==============================================================================
// Module  : hex_segment_driver
// Brief   : Registered 4-digit seven-segment driver with hex decode, raw mode,
//           per-digit blink and optional PWM dimming (macro HEX_SEG_PWM_DIM_EN).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module hex_segment_driver #(
  parameter int BLINK_DIV  = 25000000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pattern_in,
  input  logic        mode_decode,
  input  logic [3:0]  blink_mask,
  input  logic [3:0]  dim_level,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic        blink_phase
);

  localparam int             CNT_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(BLINK_DIV - 1);
  localparam logic [6:0]     SEG_OFF  = ACTIVE_LOW ? 7'h7F : 7'h00;

  // Segment table, gfedcba active-high.
  function automatic logic [6:0] decode_nibble(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  // Stage 1: input capture
  logic [31:0] pattern_q;
  logic        mode_q;
  logic [3:0]  mask_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pattern_q <= '0;
      mode_q    <= 1'b0;
      mask_q    <= '0;
    end else begin
      pattern_q <= pattern_in;
      mode_q    <= mode_decode;
      mask_q    <= blink_mask;
    end
  end

  // Free-running blink timebase; untouched by blink_mask changes.
  logic [CNT_W-1:0] blink_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == CNT_TERM) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end

  logic lit;

`ifdef HEX_SEG_PWM_DIM_EN
  logic [3:0] dim_q;
  logic [3:0] pwm_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dim_q   <= '0;
      pwm_cnt <= '0;
    end else begin
      dim_q   <= dim_level;
      pwm_cnt <= pwm_cnt + 4'd1;
    end
  end

  assign lit = (pwm_cnt <= dim_q);

  logic unused_bits;
  assign unused_bits = ^{pattern_q[31], pattern_q[23], pattern_q[15], pattern_q[7]};
`else
  assign lit = 1'b1;

  logic unused_bits;
  assign unused_bits = ^{dim_level, pattern_q[31], pattern_q[23], pattern_q[15], pattern_q[7]};
`endif

  // Stage 2: select, gate, polarity, register
  logic [6:0] hex_q [4];

  for (genvar i = 0; i < 4; i++) begin : g_digit
    logic [6:0] seg_sel;
    logic       show;
    logic [6:0] seg_gated;

    assign seg_sel   = mode_q ? decode_nibble(pattern_q[4*i +: 4]) : pattern_q[8*i +: 7];
    assign show      = lit & ~(blink_phase & mask_q[i]);
    assign seg_gated = show ? seg_sel : 7'h00;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        hex_q[i] <= SEG_OFF;
      end else begin
        hex_q[i] <= ACTIVE_LOW ? ~seg_gated : seg_gated;
      end
    end
  end

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];

endmodule

`default_nettype wire

// File: tb/tb_hex_segment_driver.sv
//==============================================================================
// Module  : tb_hex_segment_driver
// Brief   : Directed self-checking bench for hex_segment_driver (BLINK_DIV=4).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_hex_segment_driver;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pattern_in;
  logic        mode_decode;
  logic [3:0]  blink_mask;
  logic [3:0]  dim_level;
  logic [6:0]  hex0, hex1, hex2, hex3;
  logic        blink_phase;

  int n_checks = 0;
  int n_errors = 0;

  hex_segment_driver #(
    .BLINK_DIV  (4),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pattern_in  (pattern_in),
    .mode_decode (mode_decode),
    .blink_mask  (blink_mask),
    .dim_level   (dim_level),
    .hex0        (hex0),
    .hex1        (hex1),
    .hex2        (hex2),
    .hex3        (hex3),
    .blink_phase (blink_phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                           input logic [6:0] e2, input logic [6:0] e3);
    check({tag, ".hex0"}, 32'(hex0), 32'(e0));
    check({tag, ".hex1"}, 32'(hex1), 32'(e1));
    check({tag, ".hex2"}, 32'(hex2), 32'(e2));
    check({tag, ".hex3"}, 32'(hex3), 32'(e3));
  endtask

  typedef struct {
    logic        mode;
    logic [31:0] pat;
    logic [6:0]  h0, h1, h2, h3;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 32'hFFFF1234, 7'h19, 7'h30, 7'h24, 7'h79};
    vecs[1] = '{1'b0, 32'h80402001, 7'h7E, 7'h5F, 7'h3F, 7'h7F};
    vecs[2] = '{1'b1, 32'h0000ABCD, 7'h21, 7'h46, 7'h03, 7'h08};
    vecs[3] = '{1'b1, 32'h00005678, 7'h00, 7'h78, 7'h02, 7'h12};
    vecs[4] = '{1'b1, 32'h0000EF09, 7'h10, 7'h40, 7'h0E, 7'h06};

    reset_n     = 1'b0;
    pattern_in  = 32'hFFFF_FFFF;
    mode_decode = 1'b1;
    blink_mask  = 4'h0;
    dim_level   = 4'hF;

    // Reset holds everything off
    repeat (3) begin
      @(negedge clk);
      check_all("reset", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
      check("reset.phase", 32'(blink_phase), 32'd0);
    end

    // Two-clock latency after release
    pattern_in = vecs[0].pat;
    reset_n    = 1'b1;
    @(negedge clk);
    check_all("latency1", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    @(negedge clk);
    check_all("latency2", vecs[0].h0, vecs[0].h1, vecs[0].h2, vecs[0].h3);

    foreach (vecs[k]) begin
      mode_decode = vecs[k].mode;
      pattern_in  = vecs[k].pat;
      repeat (2) @(negedge clk);
      check_all($sformatf("vec%0d", k), vecs[k].h0, vecs[k].h1, vecs[k].h2, vecs[k].h3);
    end

    // Mode switch with identical glyph must not flicker
    mode_decode = 1'b1;
    pattern_in  = 32'h0000_0000;
    repeat (2) @(negedge clk);
    mode_decode = 1'b0;
    pattern_in  = 32'h3F3F_3F3F;
    repeat (3) begin
      @(negedge clk);
      check("modeswitch.hex0", 32'(hex0), 32'h40);
    end

    // Blink on digit 0 from a known reset point
    reset_n     = 1'b0;
    mode_decode = 1'b1;
    pattern_in  = 32'h0000_8888;
    blink_mask  = 4'b0001;
    @(negedge clk);
    reset_n = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      check($sformatf("blink.phase%0d", n), 32'(blink_phase), 32'((n / 4) % 2));
      if (n >= 2) begin
        check($sformatf("blink.hex0_%0d", n), 32'(hex0),
              (((n - 1) / 4) % 2 == 1) ? 32'h7F : 32'h00);
        check($sformatf("blink.hex1_%0d", n), 32'(hex1), 32'h00);
      end
    end

    // Asynchronous reset during blank phase
    #1 reset_n = 1'b0;
    #1;
    check_all("midreset", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    check("midreset.phase", 32'(blink_phase), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int m = 1; m <= 6; m++) begin
      @(negedge clk);
      check($sformatf("rel.phase%0d", m), 32'(blink_phase), 32'((m / 4) % 2));
      check($sformatf("rel.hex1_%0d", m), 32'(hex1), (m == 1) ? 32'h7F : 32'h00);
    end

    // Dimming: dim_level=3 lights 4 of every 16 clocks when enabled
    reset_n     = 1'b0;
    mode_decode = 1'b1;
    pattern_in  = 32'h0000_0000;
    blink_mask  = 4'b0000;
    dim_level   = 4'd3;
    @(negedge clk);
    reset_n = 1'b1;
    for (int n = 1; n <= 33; n++) begin
      @(negedge clk);
      if (n >= 2) begin
`ifdef HEX_SEG_PWM_DIM_EN
        check($sformatf("dim.hex0_%0d", n), 32'(hex0), (((n - 1) % 16) <= 3) ? 32'h40 : 32'h7F);
`else
        check($sformatf("dim.hex0_%0d", n), 32'(hex0), 32'h40);
`endif
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
